nibble_adder_scheduler: RTL and testbench
=========================================

# nibble_adder_scheduler

Shares one 4-bit ripple adder slice among `NREQ` requesters and sequences wide additions through it one nibble per cycle. A round-robin arbiter grants one requester at a time and captures its `WIDTH`-bit operands and carry-in. An FSM walks the nibbles LSB-first, chaining the carry, and returns a registered sum tagged with the requester ID. It sits between multiple small client blocks and the single shared adder datapath.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `WIDTH`, 16: operand width; must be a multiple of 4 and at least 4. `NIB = WIDTH/4`.
- `clk`  in  1  sole clock; rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester request level.
- `a_bus`  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `b_bus`  in  NREQ*WIDTH  operand B, same packing as `a_bus`.
- `cin`  in  NREQ  per-requester carry-in.
- `gnt`  out  NREQ  one-hot grant pulse; operands are captured on the same edge.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `done`  out  1  one-cycle result-valid pulse.
- `done_id`  out  $clog2(NREQ)  index of the requester that owns the result.
- `sum`  out  WIDTH  result, equal to (a+b+cin) mod 2^WIDTH.
- `c_out`  out  1  carry out of the top nibble.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE:**
  - If any `req` bit is high, select the first set bit searching upward from `rr_ptr`, wrapping around.
  - Drive `gnt[sel]=1` combinationally.
  - On the next edge: capture `a`, `b` and `cin` of `sel` into shift registers; store `sel`; clear the nibble counter; set `rr_ptr = (sel+1) mod NREQ`; go to RUN.
  - If no `req` bit is high, stay in IDLE with `gnt=0`.
- **RUN:**
  - Each cycle: adder slice computes `a[3:0] + b[3:0] + carry`.
  - The result nibble shifts into the sum register from the top; `a` and `b` shift right by 4; carry register updates.
  - The counter increments; after `NIB` RUN cycles, go to DONE.
  - The carry register is loaded from `cin` at capture.
- **DONE:**
  - `done=1` for exactly one cycle; `sum`, `c_out` and `done_id` are valid.
  - No grant is issued in DONE. Return to IDLE.
- **Handshake rules:**
  - A requester holds `req` and its operands until it sees `gnt`.
  - It may drop `req` in the cycle after `gnt`.
  - It may withdraw `req` before being granted; that request is then never granted.
  - `req` changes during RUN or DONE have no effect until IDLE.
- `gnt` is zero outside IDLE.
- `sum`, `c_out` and `done_id` hold their values from the last DONE until the next DONE.
- **Reset (any state, including mid-RUN):**
  - Immediately: state=IDLE, `rr_ptr=0`; shift registers, carry and counter cleared.
  - All outputs go to 0: `gnt`, `busy`, `done`, `done_id`, `sum`, `c_out`.
  - The aborted operation produces no `done`.
  - After reset, requester 0 has first priority.

## Timing
- Grant in IDLE cycle T. RUN occupies cycles T+1..T+NIB. `done` is high in cycle T+NIB+1.
- Issue interval is NIB+2 cycles; the earliest next grant is cycle T+NIB+2.
- With WIDTH=4 (NIB=1), `done` is high in cycle T+2.
- `busy` is high from T+1 through T+NIB+1 inclusive.
- All outputs are registered except `gnt`, which is combinational from state, `req` and `rr_ptr`.
- Carry chains only through the registered carry between cycles; no combinational path spans more than one nibble.

## Structure
- Shared package holds:
  - state typedef {IDLE, RUN, DONE};
  - constant `NIBBLE_W = 4`;
  - a function returning the round-robin winner index from (req, ptr).
- One sub-module, `nibble_add4`: a combinational 4-bit adder with carry-in and carry-out, instantiated once as the shared slice.
- Arbiter, FSM and shift registers stay in the top module.

## Test plan
- **Single request:** NREQ=4, WIDTH=16; `req[0]` with a=0x1234, b=0x0FFF, cin=1 -> `gnt[0]` in cycle 0; `done` in cycle 5 with sum=0x2234, c_out=0, done_id=0.
- **Full carry ripple:** a=0xFFFF, b=0x0001, cin=0 on `req[3]` -> sum=0x0000, c_out=1, done_id=3; carry propagates through all 4 nibbles.
- **Round-robin:** all four `req` held continuously -> grants in order 0,1,2,3,0, spaced 6 cycles apart; `done_id` sequence matches; `gnt` is always one-hot.
- **Late arrival and withdrawal:**
  - `req[2]` rises during requester 0's RUN -> granted at the first IDLE cycle after DONE.
  - `req[1]` raised then dropped before being granted -> never granted, no `done` for ID 1.
- **Reset mid-operation:** assert `reset` in the 2nd RUN cycle -> all outputs 0 at once, no `done` pulse; after release with all `req` high, the first grant goes to requester 0.
- **WIDTH=4 build:** a=0x9, b=0x8, cin=1 -> `done` in cycle 2 with sum=0x2, c_out=1.

Source files
------------

// File: rtl/nibble_adder_scheduler_pkg.sv
// Shared types, constants and round-robin pick for the nibble adder scheduler.
// Combinational helpers only; nothing here holds state.
package nibble_adder_scheduler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;
    localparam int MAX_REQ  = 8;

    // First set request at or above ptr, wrapping at nreq. Callers check that
    // at least one request is set; with none, ptr is returned unchanged.
    function automatic logic [2:0] rr_winner(input logic [MAX_REQ-1:0] req,
                                             input logic [2:0]         ptr,
                                             input int                 nreq);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= nreq) idx = idx - nreq;
            if (k < nreq && !found && req[idx]) begin
                win   = 3'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/nibble_adder_scheduler_if.sv
// Client-side bundle of the nibble adder scheduler: packed requests/operands in,
// grant pulse and tagged registered result out.
interface nibble_adder_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_bus;
    logic [NREQ*WIDTH-1:0] b_bus;
    logic [NREQ-1:0]       cin;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [WIDTH-1:0]      sum;
    logic                  c_out;

    modport master (
        output req, a_bus, b_bus, cin,
        input  gnt, busy, done, done_id, sum, c_out
    );

    modport slave (
        input  req, a_bus, b_bus, cin,
        output gnt, busy, done, done_id, sum, c_out
    );

endinterface

// File: rtl/nibble_adder_scheduler_add4.sv
// Shared 4-bit ripple adder slice with carry in/out; purely combinational.
module nibble_add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
    assign s    = full[3:0];
    assign co   = full[4];

endmodule

// File: rtl/nibble_adder_scheduler.sv
// Round-robin shares one nibble adder among NREQ clients; result NIB+1 cycles after grant.
// Issue interval NIB+2 cycles; clients hold req and operands until they see gnt.
module nibble_adder_scheduler
    import nibble_adder_scheduler_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    nibble_adder_scheduler_if.slave  bus
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    state_t                state;
    state_t                state_nx;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        sel;
    logic [IDW-1:0]        sel_q;
    logic                  any_req;
    logic                  capture;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      a_sel;
    logic [WIDTH-1:0]      b_sel;
    logic                  cin_sel;
    logic [WIDTH-1:0]      a_sh;
    logic [WIDTH-1:0]      b_sh;
    logic                  carry;
    logic [CW-1:0]         cnt;
    logic                  last_nib;
    logic [NIBBLE_W-1:0]   nib_sum;
    logic                  nib_cout;
    logic [WIDTH-1:0]      sum_nx;
    logic                  busy_q;
    logic                  done_q;
    logic [IDW-1:0]        done_id_q;
    logic [WIDTH-1:0]      sum_q;
    logic                  c_out_q;

    // Arbiter: winner is searched from rr_ptr upward, wrapping.
    assign any_req = |bus.req;
    assign sel     = IDW'(rr_winner(MAX_REQ'(bus.req), 3'(rr_ptr), NREQ));
    assign a_sel   = bus.a_bus[sel*WIDTH +: WIDTH];
    assign b_sel   = bus.b_bus[sel*WIDTH +: WIDTH];
    assign cin_sel = bus.cin[sel];

    assign last_nib = (cnt == CW'(NIB - 1));

    always_comb begin
        state_nx = state;
        gnt      = '0;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req && !reset) begin
                    gnt      = NREQ'(1) << sel;
                    capture  = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (last_nib) state_nx = DONE;
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    nibble_add4 u_slice (
        .a  (a_sh[NIBBLE_W-1:0]),
        .b  (b_sh[NIBBLE_W-1:0]),
        .ci (carry),
        .s  (nib_sum),
        .co (nib_cout)
    );

    // Result nibbles enter from the top; the partial holds the nibbles already
    // produced so that the final nibble completes the full-width sum.
    generate
        if (NIB > 1) begin : g_part
            logic [WIDTH-NIBBLE_W-1:0] part;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)             part <= '0;
                else if (capture)      part <= '0;
                else if (state == RUN) part <= sum_nx[WIDTH-1:NIBBLE_W];
            end
            assign sum_nx = {nib_sum, part};
        end else begin : g_single
            assign sum_nx = nib_sum;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
            sel_q  <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
        end else if (capture) begin
            rr_ptr <= (sel == IDW'(NREQ - 1)) ? '0 : sel + 1'b1;
            sel_q  <= sel;
            a_sh   <= a_sel;
            b_sh   <= b_sel;
            carry  <= cin_sel;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> NIBBLE_W;
            b_sh  <= b_sh >> NIBBLE_W;
            carry <= nib_cout;
            cnt   <= cnt + 1'b1;
        end
    end

    // Result registers only move on the last nibble, so they hold between DONEs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            sum_q     <= '0;
            c_out_q   <= 1'b0;
        end else begin
            busy_q <= (state_nx != IDLE);
            done_q <= (state_nx == DONE);
            if (state == RUN && last_nib) begin
                sum_q     <= sum_nx;
                c_out_q   <= nib_cout;
                done_id_q <= sel_q;
            end
        end
    end

    assign bus.gnt     = gnt;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.sum     = sum_q;
    assign bus.c_out   = c_out_q;

endmodule

// File: tb/tb_nibble_adder_scheduler.sv
// Directed and random checks of nibble_adder_scheduler against a transaction-level model.
module tb_nibble_adder_scheduler;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    nibble_adder_scheduler_if #(.NREQ(N), .WIDTH(W)) bus ();
    nibble_adder_scheduler #(.NREQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    nibble_adder_scheduler_if #(.NREQ(2), .WIDTH(4)) bus4 ();
    nibble_adder_scheduler #(.NREQ(2), .WIDTH(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        int           due;
    } op_t;

    typedef struct {
        int id;
        int cyc;
    } grant_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    op_t           inflight[$];
    grant_t        glog[$];
    logic [W-1:0]  a_r[N];
    logic [W-1:0]  b_r[N];
    logic          cin_r[N];
    logic [N-1:0]  pend;
    bit            rearm;
    bit            rnd;
    int            m_ptr;
    logic [W-1:0]  m_sum;
    logic          m_cout;
    int            m_id;
    int            rr_ids[5];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] p, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (p[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic new_ops(input int i);
        case ($urandom_range(0, 3))
            0:       a_r[i] = 16'hFFFF;
            default: a_r[i] = W'($urandom);
        endcase
        b_r[i]   = W'($urandom);
        cin_r[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic drive();
        bus.req = pend;
        for (int i = 0; i < N; i++) begin
            bus.a_bus[i*W +: W] = a_r[i];
            bus.b_bus[i*W +: W] = b_r[i];
            bus.cin[i]          = cin_r[i];
        end
    endtask

    task automatic run(input int n);
        for (int t = 0; t < n; t++) begin
            bit             idle;
            bit             exp_done;
            logic [N-1:0]   exp_gnt;
            logic [W:0]     full;
            int             w;
            @(posedge clk);
            #1;
            if (rnd) begin
                for (int i = 0; i < N; i++) begin
                    if (!pend[i]) begin
                        if ($urandom_range(0, 3) == 0) begin
                            new_ops(i);
                            pend[i] = 1'b1;
                        end
                    end else if ($urandom_range(0, 19) == 0) begin
                        pend[i] = 1'b0;
                    end
                end
            end
            drive();
            cyc++;
            @(negedge clk);
            idle     = (inflight.size() == 0);
            exp_done = !idle && (inflight[0].due == cyc);
            chk("busy", 32'(bus.busy), 32'(!idle));
            chk("done", 32'(bus.done), 32'(exp_done));
            if (exp_done) begin
                full   = {1'b0, inflight[0].a} + {1'b0, inflight[0].b} + (W+1)'(inflight[0].c);
                m_sum  = full[W-1:0];
                m_cout = full[W];
                m_id   = inflight[0].id;
                void'(inflight.pop_front());
            end
            chk("sum", 32'(bus.sum), 32'(m_sum));
            chk("c_out", 32'(bus.c_out), 32'(m_cout));
            chk("done_id", 32'(bus.done_id), 32'(m_id));
            exp_gnt = '0;
            w       = -1;
            if (idle && pend != '0) begin
                w       = rr_pick(pend, m_ptr);
                exp_gnt = N'(1) << w;
            end
            chk("gnt", 32'(bus.gnt), 32'(exp_gnt));
            if (w >= 0) begin
                inflight.push_back('{w, a_r[w], b_r[w], cin_r[w], cyc + NIB + 1});
                glog.push_back('{w, cyc});
                m_ptr = (w + 1) % N;
                if (rearm) new_ops(w);
                else       pend[w] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        pend  = '1;
        drive();
        #1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_done_id", 32'(bus.done_id), 0);
        chk("rst_sum", 32'(bus.sum), 0);
        chk("rst_c_out", 32'(bus.c_out), 0);
        @(posedge clk);
        #1;
        chk("rst_gnt_hold", 32'(bus.gnt), 0);
        chk("rst_done_hold", 32'(bus.done), 0);
        reset = 1'b0;
        pend  = '0;
        drive();
        inflight.delete();
        m_ptr  = 0;
        m_sum  = '0;
        m_cout = 1'b0;
        m_id   = 0;
    endtask

    initial begin
        rr_ids = '{0, 1, 2, 3, 0};
        rearm  = 1'b0;
        rnd    = 1'b0;
        pend   = '0;
        for (int i = 0; i < N; i++) begin
            a_r[i]   = '0;
            b_r[i]   = '0;
            cin_r[i] = 1'b0;
        end
        drive();
        bus4.req   = '0;
        bus4.a_bus = '0;
        bus4.b_bus = '0;
        bus4.cin   = '0;

        do_reset();

        // Single request on requester 0.
        a_r[0] = 16'h1234; b_r[0] = 16'h0FFF; cin_r[0] = 1'b1;
        pend = 4'b0001;
        glog.delete();
        run(7);
        chk("single_sum", 32'(bus.sum), 32'h2234);
        chk("single_c_out", 32'(bus.c_out), 0);
        chk("single_id", 32'(bus.done_id), 0);

        // Carry ripples through every nibble.
        a_r[3] = 16'hFFFF; b_r[3] = 16'h0001; cin_r[3] = 1'b0;
        pend = 4'b1000;
        run(7);
        chk("ripple_sum", 32'(bus.sum), 0);
        chk("ripple_c_out", 32'(bus.c_out), 1);
        chk("ripple_id", 32'(bus.done_id), 3);

        // All requesters held: strict rotation at the issue interval.
        glog.delete();
        for (int i = 0; i < N; i++) new_ops(i);
        pend  = '1;
        rearm = 1'b1;
        run(30);
        rearm = 1'b0;
        pend  = '0;
        run(8);
        chk("rr_count", 32'(glog.size() >= 5), 1);
        for (int k = 0; k < 5 && k < glog.size(); k++) begin
            chk("rr_order", 32'(glog[k].id), 32'(rr_ids[k]));
            if (k > 0) chk("rr_spacing", 32'(glog[k].cyc - glog[k-1].cyc), NIB + 2);
        end

        // Late arrival of 2 and a withdrawn request from 1.
        glog.delete();
        new_ops(0);
        pend = 4'b0001;
        run(2);
        new_ops(1);
        new_ops(2);
        pend[1] = 1'b1;
        pend[2] = 1'b1;
        run(1);
        pend[1] = 1'b0;
        run(12);
        chk("late_count", 32'(glog.size()), 2);
        if (glog.size() >= 2) begin
            chk("late_first", 32'(glog[0].id), 0);
            chk("late_second", 32'(glog[1].id), 2);
            chk("late_spacing", 32'(glog[1].cyc - glog[0].cyc), NIB + 2);
        end

        // Reset during the second RUN cycle.
        new_ops(0);
        pend = 4'b0001;
        run(2);
        chk("pre_reset_busy", 32'(bus.busy), 1);
        do_reset();
        for (int i = 0; i < N; i++) new_ops(i);
        pend = '1;
        run(1);
        chk("post_reset_gnt", 32'(bus.gnt), 32'h1);
        run(26);

        // Random traffic with arbitrary arrivals and withdrawals.
        rnd = 1'b1;
        run(400);
        rnd  = 1'b0;
        pend = '0;
        run(10);

        // WIDTH=4 instance: result two cycles after grant.
        @(posedge clk);
        #1;
        bus4.req = 2'b01; bus4.a_bus = 8'h09; bus4.b_bus = 8'h08; bus4.cin = 2'b01;
        @(negedge clk);
        chk("w4_gnt", 32'(bus4.gnt), 32'h1);
        chk("w4_busy_grant", 32'(bus4.busy), 0);
        @(posedge clk);
        #1;
        bus4.req = 2'b00;
        @(negedge clk);
        chk("w4_gnt_run", 32'(bus4.gnt), 0);
        chk("w4_busy_run", 32'(bus4.busy), 1);
        chk("w4_done_early", 32'(bus4.done), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w4_done", 32'(bus4.done), 1);
        chk("w4_sum", 32'(bus4.sum), 32'h2);
        chk("w4_c_out", 32'(bus4.c_out), 1);
        chk("w4_id", 32'(bus4.done_id), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("w4_done_pulse", 32'(bus4.done), 0);
        chk("w4_sum_hold", 32'(bus4.sum), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
